four_bit_ripple_carry_adder: RTL and testbench
==============================================

Name: four_bit_ripple_carry_adder

Overview:
- Registered 4-bit ripple-carry adder: S/Cout = A + B + Cin.
- Datapath is a chain of WIDTH full-adder cells, carry rippling LSB to MSB.
- Single-clock arithmetic leaf used by datapath blocks.
- Sum, carry-out and a signed-overflow flag are captured in output registers, qualified by a valid strobe.

Parameters:
- WIDTH, 4, operand/sum width in bits. Only 4 is verified; must be >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- in_valid  input  1  operands valid this cycle
- A  input  WIDTH  operand A, unsigned (two's complement for V)
- B  input  WIDTH  operand B
- Cin  input  1  carry-in
- S  output  WIDTH  registered sum bits
- Cout  output  1  registered carry-out of MSB cell
- V  output  1  registered signed overflow: carry into MSB XOR carry out of MSB
- out_valid  output  1  S/Cout/V hold a fresh result

Behaviour:
- Combinational core:
  - WIDTH full-adder cells with s_i = a_i ^ b_i ^ c_i and c_{i+1} = a_i&b_i | c_i&(a_i^b_i).
  - c_0 = Cin; Cout = c_WIDTH; V = c_{WIDTH-1} ^ c_WIDTH.
  - Result must equal {Cout,S} = A + B + Cin, range 0..31 for WIDTH=4.
- Reset:
  - rst_n low at a rising clk edge forces S=0, Cout=0, V=0, out_valid=0.
  - Reset overrides in_valid in the same cycle.
  - No asynchronous path from rst_n.
- Latency (base configuration): 1 cycle.
  - If in_valid=1 at edge n, then S/Cout/V reflect A/B/Cin sampled at edge n, and out_valid=1 after edge n.
  - If in_valid=0 at an edge, S/Cout/V hold their previous values and out_valid=0.
- Throughput: one result per cycle; back-to-back in_valid is accepted with no bubbles. There is no backpressure.
- Wrap-around: the sum is modulo 2^WIDTH and the lost bit appears on Cout.
  - Example: F+F+1 gives S=F, Cout=1.
- Reset mid-operation: an operand accepted at the same edge as reset is discarded. out_valid stays 0 on the next cycle.
- Unknown (X) inputs while in_valid=0 must not disturb the held outputs.

Optional Feature:
- Macro: FOUR_BIT_RCA_INPUT_REG_EN
- Defined:
  - A, B, Cin and in_valid are first captured in an input register stage (reset to 0 by rst_n). The adder chain operates on the registered operands.
  - Latency becomes 2 cycles, still one result per cycle.
  - A reset clears both stages.
- Undefined: 1-cycle latency as above, with no input register.

Test Plan:
- Exhaustive: with rst_n=1 and in_valid=1, sweep Cin in {0,1}, A 0..F and B 0..F (512 vectors, 10 ns apart) -> each result, 1 cycle later (2 with the macro), satisfies {Cout,S} = A+B+Cin.
- Carry ripple and wrap: A=F, B=0, Cin=1 -> S=0, Cout=1, V=0. A=F, B=F, Cin=1 -> S=F, Cout=1.
- Signed overflow: A=7, B=1, Cin=0 -> S=8, Cout=0, V=1. A=8, B=8, Cin=0 -> S=0, Cout=1, V=1.
- Hold: issue A=3, B=4, Cin=0 with in_valid=1, then drive in_valid=0 with A=F, B=F -> S stays 7, Cout 0, out_valid drops to 0.
- Reset mid-stream: back-to-back valid operands, assert rst_n=0 for one edge together with A=5, B=5 -> S=0, Cout=0, V=0, out_valid=0. Discarded operand never appears; the next valid operand yields the correct sum.
- Zero case: A=0, B=0, Cin=0 -> S=0, Cout=0. Same with Cin=1 -> S=1, Cout=0.

Source files
------------

// File: rtl/four_bit_ripple_carry_adder.sv
// Registered WIDTH-bit ripple-carry adder producing sum, carry-out and signed overflow.
// Define FOUR_BIT_RCA_INPUT_REG_EN to add an input register stage (2-cycle latency).
module four_bit_ripple_carry_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic             out_valid
);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             op_valid;

`ifdef FOUR_BIT_RCA_INPUT_REG_EN
  // Operands load only when valid so unknown inputs on idle cycles never enter the chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a     <= '0;
      op_b     <= '0;
      op_cin   <= 1'b0;
      op_valid <= 1'b0;
    end else begin
      op_valid <= in_valid;
      if (in_valid) begin
        op_a   <= A;
        op_b   <= B;
        op_cin <= Cin;
      end
    end
  end
`else
  assign op_a     = A;
  assign op_b     = B;
  assign op_cin   = Cin;
  assign op_valid = in_valid;
`endif

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = op_cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i]     = op_a[i] ^ op_b[i] ^ carry[i];
      carry[i+1] = (op_a[i] & op_b[i]) | (carry[i] & (op_a[i] ^ op_b[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      S         <= '0;
      Cout      <= 1'b0;
      V         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= op_valid;
      if (op_valid) begin
        S    <= sum;
        Cout <= carry[WIDTH];
        V    <= carry[WIDTH-1] ^ carry[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_four_bit_ripple_carry_adder.sv
// Directed and exhaustive self-checking bench for four_bit_ripple_carry_adder.
// Latency follows FOUR_BIT_RCA_INPUT_REG_EN (1 cycle undefined, 2 cycles defined).
module tb_four_bit_ripple_carry_adder;

`ifdef FOUR_BIT_RCA_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] s;
  logic       cout;
  logic       v;
  logic       out_valid;

  int checks   = 0;
  int failures = 0;

  four_bit_ripple_carry_adder #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .A        (a),
    .B        (b),
    .Cin      (cin),
    .S        (s),
    .Cout     (cout),
    .V        (v),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one operand, then idle with junk operands until its result is visible.
  task automatic op(input logic [3:0] oa, input logic [3:0] ob, input logic oc);
    @(negedge clk);
    a = oa; b = ob; cin = oc; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; a = 4'hF; b = 4'hF; cin = 1'b1;
    repeat (LAT - 1) @(negedge clk);
  endtask

  task automatic check_result(input string tag, input logic [3:0] es, input logic ec,
                              input logic ev);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_s"}, 32'(s), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_v"}, 32'(v), 32'(ev));
  endtask

  initial begin
    logic [8:0] j;
    logic [3:0] ea, eb;
    logic       ec;
    logic [4:0] esum;
    logic [8:0] kv;

    rst_n = 1'b0; in_valid = 1'b1; a = 4'h9; b = 4'h9; cin = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_s", 32'(s), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    check("reset_v", 32'(v), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1; in_valid = 1'b0;

    // Zero cases
    op(4'h0, 4'h0, 1'b0); check_result("zero_c0", 4'h0, 1'b0, 1'b0);
    op(4'h0, 4'h0, 1'b1); check_result("zero_c1", 4'h1, 1'b0, 1'b0);

    // Carry ripple and wrap-around
    op(4'hF, 4'h0, 1'b1); check_result("ripple", 4'h0, 1'b1, 1'b0);
    op(4'hF, 4'hF, 1'b1); check_result("wrap", 4'hF, 1'b1, 1'b0);

    // Signed overflow
    op(4'h7, 4'h1, 1'b0); check_result("ovf_pos", 4'h8, 1'b0, 1'b1);
    op(4'h8, 4'h8, 1'b0); check_result("ovf_neg", 4'h0, 1'b1, 1'b1);

    // Hold: idle cycle with different (and unknown) operands keeps previous result
    op(4'h3, 4'h4, 1'b0); check_result("hold_pre", 4'h7, 1'b0, 1'b0);
    a = 4'bxxxx; b = 4'bxxxx; cin = 1'bx;
    @(negedge clk);
    check("hold_valid", 32'(out_valid), 32'd0);
    check("hold_s", 32'(s), 32'd7);
    check("hold_cout", 32'(cout), 32'd0);
    check("hold_v", 32'(v), 32'd0);

    // Reset mid-stream: operand presented with reset is discarded
    @(negedge clk);
    a = 4'h1; b = 4'h2; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 4'h5; b = 4'h5; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; a = 4'h0; b = 4'h0;
    check("rst_mid_s", 32'(s), 32'd0);
    check("rst_mid_cout", 32'(cout), 32'd0);
    check("rst_mid_v", 32'(v), 32'd0);
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    repeat (LAT) begin
      @(negedge clk);
      check("rst_discard_valid", 32'(out_valid), 32'd0);
      check("rst_discard_s", 32'(s), 32'd0);
    end
    op(4'h6, 4'h7, 1'b1); check_result("post_rst", 4'hE, 1'b0, 1'b1);

    // Exhaustive back-to-back sweep
    for (int k = 0; k < 512 + LAT; k++) begin
      @(negedge clk);
      if (k >= LAT) begin
        j    = 9'(k - LAT);
        ec   = j[8];
        ea   = j[7:4];
        eb   = j[3:0];
        esum = 5'(ea) + 5'(eb) + 5'(ec);
        check("sweep_valid", 32'(out_valid), 32'd1);
        check("sweep_s", 32'(s), 32'(esum[3:0]));
        check("sweep_cout", 32'(cout), 32'(esum[4]));
        check("sweep_v", 32'(v), 32'((ea[3] == eb[3]) && (esum[3] != ea[3])));
      end
      if (k < 512) begin
        kv = 9'(k);
        cin = kv[8]; a = kv[7:4]; b = kv[3:0]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("sweep_end_valid", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
